// File: rtl/aqed_sched_pkg.sv
// Shared types and defaults for the A-QED duplicate-write scheduler.
package aqed_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    GAP,
    DUP,
    WAIT,
    DONE
  } state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int GAP_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W        = $clog2(TIMEOUT_DEF + 1);

  // A run is in progress from arming until the verdict is latched.
  function automatic logic is_busy(input state_e s);
    return (s == ARMED) || (s == GAP) || (s == DUP) || (s == WAIT);
  endfunction

endpackage

// File: rtl/aqed_sched_watchdog.sv
// Saturating WAIT-phase watchdog for aqed_dup_scheduler.
// Only exists when AQED_TIMEOUT_EN is defined.
`ifdef AQED_TIMEOUT_EN
module aqed_sched_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the enabled cycle whose count would reach TIMEOUT.
  assign expired = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/aqed_dup_scheduler.sv
// A-QED self-consistency sequencer: marks the original and duplicate write,
// then waits for the checker verdict. AQED_TIMEOUT_EN adds a WAIT watchdog.
module aqed_dup_scheduler
  import aqed_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_cfg,
  input  logic              stim_valid,
  input  logic [DATA_W-1:0] stim_data,
  output logic              stim_ready,
  output logic              dut_wen,
  output logic [DATA_W-1:0] dut_data,
  output logic              exec_dup,
  input  logic              qed_done_in,
  input  logic              qed_check_in,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             accept;
  logic             wd_clr;
  logic             wd_expired;

`ifdef AQED_TIMEOUT_EN
  aqed_sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (clk_en && (state_q == WAIT)),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  assign stim_ready = is_busy(state_q);
  assign busy       = is_busy(state_q);
  assign exec_dup   = (state_q == ARMED) || (state_q == DUP);
  assign accept     = clk_en && stim_valid && stim_ready && !flush;
  assign dut_wen    = accept;
  assign dut_data   = stim_data;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    wd_clr    = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE, DONE: begin
          // Abort has priority everywhere, including over a fresh start.
          if (start && !flush) begin
            state_d   = ARMED;
            gap_cnt_d = gap_cfg;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        ARMED: begin
          if (flush) begin
            state_d = IDLE;
          end else if (accept) begin
            state_d = (gap_cnt_q == '0) ? DUP : GAP;
          end
        end
        GAP: begin
          if (flush) begin
            state_d = IDLE;
          end else if (accept) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            if (gap_cnt_q == GAP_W'(1)) begin
              state_d = DUP;
            end
          end
        end
        DUP: begin
          if (flush) begin
            state_d = IDLE;
          end else if (accept) begin
            state_d = WAIT;
            wd_clr  = 1'b1;
          end
        end
        WAIT: begin
          if (flush) begin
            state_d = IDLE;
          end else if (qed_done_in) begin
            state_d = DONE;
            pass_d  = qed_check_in;
            fail_d  = !qed_check_in;
          end else if (wd_expired) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            fail_d    = 1'b1;
            pass_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`ifdef AQED_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
